// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encoding and helpers used by the
// button front end and by the game core.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int N_BUTTONS   = 4;
    localparam int QUEUE_DEPTH = 2;

    // Up/down and left/right differ only in bit 0, so flipping it reverses.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/arrow_input_if.sv
// Board-button and game-core handshake signals of the arrow input block.
interface arrow_input_if #(
    parameter int SEED_W = 26
);
    logic              arrow_up;
    logic              arrow_down;
    logic              arrow_left;
    logic              arrow_right;
    logic              step;
    logic [1:0]        arrow;
    logic              press;
    logic [SEED_W-1:0] seed;

    modport master (
        output arrow_up,
        output arrow_down,
        output arrow_left,
        output arrow_right,
        output step,
        input  arrow,
        input  press,
        input  seed
    );

    modport slave (
        input  arrow_up,
        input  arrow_down,
        input  arrow_left,
        input  arrow_right,
        input  step,
        output arrow,
        output press,
        output seed
    );
endinterface

// File: rtl/arrow_input_debounce.sv
// One button channel: 2-flop synchroniser, stability-counting debouncer and a
// registered one-cycle pulse on each debounced 0->1 transition.
module debounce #(
    parameter int CYCLES = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/arrow_input.sv
// Arrow-button front end: per-button conditioning, priority select, reversal
// rejection, 2-entry direction queue and press-sampled apple seed.
module arrow_input
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int SEED_W          = 26
) (
    input  logic          clk,
    input  logic          reset,
    arrow_input_if.slave  bus
);
    logic [N_BUTTONS-1:0] raw_norm;
    logic [N_BUTTONS-1:0] rise;

    // Bit order matches dir_t; up/down buttons are active-low on the board.
    assign raw_norm = {bus.arrow_right, bus.arrow_left, ~bus.arrow_down, ~bus.arrow_up};

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_norm[gi]),
            .rise_o (rise[gi])
        );
    end

    logic win_valid;
    dir_t win_dir;

    always_comb begin
        win_valid = |rise;
        win_dir   = DIR_UP;
        if (rise[0]) begin
            win_dir = DIR_UP;
        end else if (rise[1]) begin
            win_dir = DIR_DOWN;
        end else if (rise[2]) begin
            win_dir = DIR_LEFT;
        end else if (rise[3]) begin
            win_dir = DIR_RIGHT;
        end
    end

    dir_t              arrow_q;
    dir_t              arrow_d;
    dir_t              head_q;
    dir_t              head_d;
    dir_t              tail_q;
    dir_t              tail_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [SEED_W-1:0] ctr_q;
    logic [SEED_W-1:0] ctr_d;
    logic [SEED_W-1:0] seed_q;
    logic [SEED_W-1:0] seed_d;
    dir_t              ref_dir;
    logic              pop;
    logic              accept;

    // Pop first so a press in the same cycle sees the post-step reference
    // and can use the slot the step just freed.
    always_comb begin
        arrow_d = arrow_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        seed_d  = seed_q;
        ctr_d   = ctr_q + SEED_W'(1);
        ref_dir = arrow_q;
        accept  = 1'b0;

        pop = bus.step && (count_q != 2'd0);
        if (pop) begin
            arrow_d = head_q;
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end

        if (count_d == 2'd2) begin
            ref_dir = tail_d;
        end else if (count_d == 2'd1) begin
            ref_dir = head_d;
        end else begin
            ref_dir = arrow_d;
        end

        accept = win_valid
              && (win_dir != ref_dir)
              && (win_dir != opposite(ref_dir))
              && (count_d != 2'(QUEUE_DEPTH));

        if (accept) begin
            if (count_d == 2'd0) begin
                head_d = win_dir;
            end else begin
                tail_d = win_dir;
            end
            count_d = count_d + 2'd1;
            seed_d  = seed_q ^ ctr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            arrow_q <= DIR_DOWN;
            head_q  <= DIR_UP;
            tail_q  <= DIR_UP;
            count_q <= 2'd0;
            ctr_q   <= '0;
            seed_q  <= '0;
        end else begin
            arrow_q <= arrow_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ctr_q   <= ctr_d;
            seed_q  <= seed_d;
        end
    end

    assign bus.arrow = arrow_q;
    assign bus.press = win_valid;
    assign bus.seed  = seed_q;

endmodule

// File: tb/tb_arrow_input.sv
// Self-checking bench for arrow_input: directed scenarios plus randomized
// buttons/steps/resets compared cycle by cycle against a behavioural model.
module tb_arrow_input;
    localparam int C  = 4;
    localparam int SW = 26;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arrow_input_if #(.SEED_W(SW)) bus ();

    arrow_input #(
        .DEBOUNCE_CYCLES (C),
        .SEED_W          (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [1:0]    m_arrow;
    logic [SW-1:0] m_seed;
    logic [SW-1:0] m_cnt;
    bit            m_press;
    int            m_q[$];
    bit            m_level[4];
    bit            m_rise[4];
    bit            m_hist[4][C+2];

    function automatic bit norm_btn(input int b);
        case (b)
            0:       return !bus.arrow_up;
            1:       return !bus.arrow_down;
            2:       return bus.arrow_left;
            default: return bus.arrow_right;
        endcase
    endfunction

    // A level flips once the last C synchronised samples (2 edges late) all
    // disagree with it; a press is a flip to pressed.
    task automatic model_step();
        int  win;
        int  refd;
        bit  all_diff;
        if (!reset) begin
            m_arrow = 2'd1;
            m_seed  = '0;
            m_cnt   = '0;
            m_q.delete();
            for (int b = 0; b < 4; b++) begin
                m_level[b] = 1'b0;
                m_rise[b]  = 1'b0;
                for (int j = 0; j < C + 2; j++) m_hist[b][j] = 1'b0;
            end
        end else begin
            win = -1;
            for (int b = 3; b >= 0; b--) if (m_rise[b]) win = b;
            if (bus.step && m_q.size() > 0) m_arrow = 2'(m_q.pop_front());
            if (win >= 0) begin
                refd = (m_q.size() > 0) ? m_q[$] : int'(m_arrow);
                if ((win / 2) != (refd / 2) && m_q.size() < 2) begin
                    m_q.push_back(win);
                    m_seed = m_seed ^ m_cnt;
                end
            end
            m_cnt = m_cnt + 1'b1;
            for (int b = 0; b < 4; b++) begin
                for (int j = C + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
                m_hist[b][0] = norm_btn(b);
                all_diff = 1'b1;
                for (int j = 2; j <= C + 1; j++) if (m_hist[b][j] == m_level[b]) all_diff = 1'b0;
                m_rise[b] = all_diff && !m_level[b];
                if (all_diff) m_level[b] = !m_level[b];
            end
        end
        m_press = m_rise[0] | m_rise[1] | m_rise[2] | m_rise[3];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_btn(input int b, input bit pressed);
        case (b)
            0:       bus.arrow_up    = ~pressed;
            1:       bus.arrow_down  = ~pressed;
            2:       bus.arrow_left  = pressed;
            default: bus.arrow_right = pressed;
        endcase
    endtask

    task automatic release_all();
        for (int b = 0; b < 4; b++) set_btn(b, 1'b0);
        bus.step = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        cycle();
        bus.step = 1'b0;
    endtask

    task automatic tap(input int b, output int pulses);
        pulses = 0;
        set_btn(b, 1'b1);
        repeat (8) begin
            cycle();
            if (bus.press === 1'b1) pulses++;
        end
        set_btn(b, 1'b0);
        repeat (8) begin
            cycle();
            if (bus.press === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        release_all();
        reset = 1'b0;
        cycle();
        cycle();
        tests_run++;
        if (bus.arrow !== 2'd1 || bus.press !== 1'b0 || bus.seed !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: arrow=%0d press=%0d seed=%0d, expected 1 0 0", bus.arrow, bus.press, bus.seed);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_step();
            tests_run++;
            if (bus.arrow !== 2'd1 || bus.press !== 1'b0 || bus.seed !== '0) begin
                tests_failed++;
                $display("FAIL idle_step %0d: arrow=%0d press=%0d seed=%0d, expected 1 0 0", i, bus.arrow, bus.press, bus.seed);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_press();
        int press_at = -1;
        int pulses   = 0;
        do_reset();
        set_btn(3, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (bus.press === 1'b1) begin
                pulses++;
                press_at = i;
            end
        end
        tests_run++;
        if (pulses != 1 || press_at != C + 2) begin
            tests_failed++;
            $display("FAIL press_timing: pulses=%0d at=%0d, expected 1 at %0d", pulses, press_at, C + 2);
        end
        tests_run++;
        if (bus.seed !== SW'(C + 2)) begin
            tests_failed++;
            $display("FAIL press_seed: seed=%0d expected %0d", bus.seed, C + 2);
        end
        do_step();
        tests_run++;
        if (bus.arrow !== 2'd3) begin
            tests_failed++;
            $display("FAIL press_arrow: arrow=%0d expected 3", bus.arrow);
        end
        set_btn(3, 1'b0);
        repeat (8) cycle();
        $display("[TB] test_single_press done: press at cycle %0d", press_at);
    endtask

    task automatic test_bounce();
        int pulses   = 0;
        int press_at = -1;
        for (int k = 0; k < 4; k++) begin
            set_btn(3, (k % 2) == 0);
            repeat (2) begin
                cycle();
                if (bus.press === 1'b1) pulses++;
            end
        end
        set_btn(3, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (bus.press === 1'b1) begin
                pulses++;
                press_at = i;
            end
            tests_run++;
            if (bus.press !== m_press) begin
                tests_failed++;
                $display("FAIL bounce_press cyc %0d: press=%0d expected %0d", i, bus.press, m_press);
            end
        end
        tests_run++;
        if (pulses != 1 || press_at != C + 2) begin
            tests_failed++;
            $display("FAIL bounce_count: pulses=%0d at=%0d, expected 1 at %0d", pulses, press_at, C + 2);
        end
        set_btn(3, 1'b0);
        repeat (8) cycle();
        $display("[TB] test_bounce done: %0d pulse(s)", pulses);
    endtask

    task automatic test_reversal();
        int pulses;
        do_reset();
        tap(0, pulses);
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL reversal_press: pulses=%0d expected 1", pulses);
        end
        do_step();
        tests_run++;
        if (bus.arrow !== 2'd1) begin
            tests_failed++;
            $display("FAIL reversal_arrow: arrow=%0d expected 1", bus.arrow);
        end
        $display("[TB] test_reversal done");
    endtask

    task automatic test_queue_full();
        int pulses;
        int exp_arrow[3] = '{2, 0, 0};
        do_reset();
        tap(2, pulses);
        tap(0, pulses);
        tap(3, pulses);
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL full_press: pulses=%0d expected 1", pulses);
        end
        for (int i = 0; i < 3; i++) begin
            do_step();
            tests_run++;
            if (bus.arrow !== 2'(exp_arrow[i])) begin
                tests_failed++;
                $display("FAIL full_step %0d: arrow=%0d expected %0d", i, bus.arrow, exp_arrow[i]);
            end
        end
        $display("[TB] test_queue_full done");
    endtask

    task automatic test_back_to_back();
        int pulses;
        int exp_arrow[5] = '{0, 3, 3, 0, 0};
        do_reset();
        tap(2, pulses);
        tap(0, pulses);
        set_btn(3, 1'b1);
        repeat (C + 2) cycle();
        tests_run++;
        if (bus.press !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_press: press=%0d expected 1", bus.press);
        end
        do_step();
        tests_run++;
        if (bus.arrow !== 2'd2) begin
            tests_failed++;
            $display("FAIL b2b_pop: arrow=%0d expected 2", bus.arrow);
        end
        set_btn(3, 1'b0);
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) begin
            do_step();
            tests_run++;
            if (bus.arrow !== 2'(exp_arrow[i])) begin
                tests_failed++;
                $display("FAIL b2b_step %0d: arrow=%0d expected %0d", i, bus.arrow, exp_arrow[i]);
            end
        end
        set_btn(0, 1'b1);
        set_btn(2, 1'b1);
        pulses = 0;
        repeat (8) begin
            cycle();
            if (bus.press === 1'b1) pulses++;
        end
        set_btn(0, 1'b0);
        set_btn(2, 1'b0);
        repeat (8) cycle();
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL simul_press: pulses=%0d expected 1", pulses);
        end
        for (int i = 3; i < 5; i++) begin
            do_step();
            tests_run++;
            if (bus.arrow !== 2'(exp_arrow[i])) begin
                tests_failed++;
                $display("FAIL simul_step %0d: arrow=%0d expected %0d", i, bus.arrow, exp_arrow[i]);
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        int pulses;
        do_reset();
        tap(2, pulses);
        do_reset();
        tests_run++;
        if (bus.arrow !== 2'd1 || bus.seed !== '0) begin
            tests_failed++;
            $display("FAIL midreset_state: arrow=%0d seed=%0d expected 1 0", bus.arrow, bus.seed);
        end
        do_step();
        tests_run++;
        if (bus.arrow !== 2'd1) begin
            tests_failed++;
            $display("FAIL midreset_queue: arrow=%0d expected 1", bus.arrow);
        end
        $display("[TB] test_mid_reset done");
    endtask

    task automatic test_random();
        int hold[4] = '{0, 0, 0, 0};
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    set_btn(b, 1'($urandom_range(0, 1)));
                    hold[b] = $urandom_range(1, 10);
                end
                hold[b]--;
            end
            bus.step = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 399) != 0);
            cycle();
            tests_run++;
            if (bus.arrow !== m_arrow || bus.press !== m_press || bus.seed !== m_seed) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc %0d: arrow=%0d press=%0d seed=%0h, expected %0d %0d %0h",
                             i, bus.arrow, bus.press, bus.seed, m_arrow, m_press, m_seed);
            end
        end
        reset = 1'b1;
        release_all();
        $display("[TB] test_random done");
    endtask

    initial begin
        reset = 1'b0;
        release_all();
        test_reset();
        test_single_press();
        test_bounce();
        test_reversal();
        test_queue_full();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
